// File: rtl/p2_branch_resolve_if.sv
// Fetch <-> branch-resolve stage bundle for the SIMPLE core.
// The master side (fetch/execute) drives the word and flags; the slave side (the stage) drives the results.
interface p2_branch_resolve_if;
  logic [15:0] operation_in;
  logic [3:0]  flags_in;
  logic        pcsrcout;
  logic [15:0] pctargetout;
  logic [15:0] operation_out;
  logic        op_valid;
  logic        halted;

  modport master (
    output operation_in, flags_in,
    input  pcsrcout, pctargetout, operation_out, op_valid, halted
  );

  modport slave (
    input  operation_in, flags_in,
    output pcsrcout, pctargetout, operation_out, op_valid, halted
  );
endinterface

// File: rtl/p2_branch_resolve.sv
// SIMPLE core stage 2: resolves branches, squashes wrong-path words and stops issue on HLT.
// Optional BRANCH_STATS_EN adds taken_count/squash_count statistics outputs.
module p2_branch_resolve #(
  parameter int FETCH_LAG    = 2,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  p2_branch_resolve_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]          taken_count,
  output logic [15:0]          squash_count
`endif
);

  localparam logic [1:0]  ST_RUN    = 2'b00;
  localparam logic [1:0]  ST_SQUASH = 2'b01;
  localparam logic [1:0]  ST_HALT   = 2'b10;
  localparam logic [15:0] LAG_C     = 16'(FETCH_LAG);
  localparam logic [2:0]  SLOTS_C   = 3'(SQUASH_SLOTS);

  // Flags are {S,Z,C,V}; conditions 101..111 never take.
  function automatic logic cond_taken(input logic [2:0] cond, input logic [3:0] f);
    logic res;
    case (cond)
      3'b000:  res = 1'b1;
      3'b001:  res = f[2];
      3'b010:  res = f[3] ^ f[0];
      3'b011:  res = f[2] | (f[3] ^ f[0]);
      3'b100:  res = ~f[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        pcsrc_r, pcsrc_s;
  logic [15:0] target_r, target_s;
  logic [15:0] opout_r, opout_s;
  logic        valid_r, valid_s;
  logic        halted_r, halted_s;
  logic        is_branch_s, is_hlt_s, taken_s;
  logic [15:0] offset_s;

  assign is_branch_s = (bus.operation_in[15:11] == 5'b10111);
  assign is_hlt_s    = (bus.operation_in[15:14] == 2'b11) && (bus.operation_in[7:4] == 4'b1111);
  assign taken_s     = is_branch_s && cond_taken(bus.operation_in[10:8], bus.flags_in);
  assign offset_s    = {{8{bus.operation_in[7]}}, bus.operation_in[7:0]} - LAG_C;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pcsrc_s  = 1'b0;
    target_s = target_r;
    opout_s  = opout_r;
    valid_s  = 1'b0;
    halted_s = halted_r;
    case (state_r)
      ST_RUN: begin
        if (taken_s) begin
          pcsrc_s  = 1'b1;
          target_s = offset_s;
          state_s  = ST_SQUASH;
          cnt_s    = SLOTS_C;
        end else if (is_hlt_s) begin
          opout_s  = bus.operation_in;
          valid_s  = 1'b1;
          halted_s = 1'b1;
          state_s  = ST_HALT;
        end else begin
          opout_s  = bus.operation_in;
          valid_s  = 1'b1;
        end
      end
      ST_SQUASH: begin
        // A zero count cannot occur legally; fall back to RUN rather than wrap.
        if (cnt_r <= 3'd1) begin
          cnt_s   = 3'd0;
          state_s = ST_RUN;
        end else begin
          cnt_s   = cnt_r - 3'd1;
          state_s = ST_SQUASH;
        end
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s = ST_RUN;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Pipeline state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RUN;
      cnt_r    <= 3'd0;
      pcsrc_r  <= 1'b0;
      target_r <= 16'h0000;
      opout_r  <= 16'h0000;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pcsrc_r  <= pcsrc_s;
      target_r <= target_s;
      opout_r  <= opout_s;
      valid_r  <= valid_s;
      halted_r <= halted_s;
    end
  end

  assign bus.pcsrcout      = pcsrc_r;
  assign bus.pctargetout   = target_r;
  assign bus.operation_out = opout_r;
  assign bus.op_valid      = valid_r;
  assign bus.halted        = halted_r;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_r, squash_cnt_r;

  // Redirect and discarded-word counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_r  <= 16'h0000;
      squash_cnt_r <= 16'h0000;
    end else begin
      if (pcsrc_s) begin
        taken_cnt_r <= taken_cnt_r + 16'h0001;
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
      if (state_r == ST_SQUASH) begin
        squash_cnt_r <= squash_cnt_r + 16'h0001;
      end else begin
        squash_cnt_r <= squash_cnt_r;
      end
    end
  end

  assign taken_count  = taken_cnt_r;
  assign squash_count = squash_cnt_r;
`endif

endmodule
